serial_thermo_to_scomp: RTL and testbench

SERIAL_THERMO_TO_SCOMP -- requirements
Module: serial_thermo_to_scomp

---
 rtl/serial_thermo_to_scomp.sv | 121 ++++++++++++
 tb/tb_serial_thermo_to_scomp.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_thermo_to_scomp.sv
`default_nettype none
// ============================================================================
// Module   : serial_thermo_to_scomp
// Brief    : Collects a serial thermometer code (ones first), counts its ones
//            and returns a signed two's-complement magnitude with a
//            code-validity flag, using a valid/ready result handshake.
// Revision : 1.0 - initial release
// ============================================================================
module serial_thermo_to_scomp #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sign_in,
    input  logic         bit_valid,
    input  logic         bit_in,
    input  logic         result_ready,
    output logic         busy,
    output logic         result_valid,
    output logic [N:0]   result,
    output logic         code_error
);

    localparam int           c_TOTAL_BITS = (2 ** N) - 1;
    localparam logic [N-1:0] c_LAST_IDX   = N'(c_TOTAL_BITS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CONVERT = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_bit_cnt;
    logic [N-1:0] r_ones_cnt;
    logic         r_seen_zero;
    logic         r_sign;
    logic         r_busy;
    logic         r_result_valid;
    logic [N:0]   r_result;
    logic         r_code_error;

    logic [N:0]   w_mag;

    // Negating a zero magnitude yields zero, so no negative zero can appear.
    assign w_mag = {1'b0, r_ones_cnt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_bit_cnt      <= '0;
            r_ones_cnt     <= '0;
            r_seen_zero    <= 1'b0;
            r_sign         <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result       <= '0;
            r_code_error   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bit_cnt    <= '0;
                        r_ones_cnt   <= '0;
                        r_seen_zero  <= 1'b0;
                        r_code_error <= 1'b0;
                        r_sign       <= sign_in;
                        r_busy       <= 1'b1;
                        r_state      <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (bit_valid) begin
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        r_ones_cnt <= r_ones_cnt + {{(N-1){1'b0}}, bit_in};
                        if (!bit_in) begin
                            r_seen_zero <= 1'b1;
                        end else if (r_seen_zero) begin
                            r_code_error <= 1'b1;
                        end
                        if (r_bit_cnt == c_LAST_IDX) begin
                            r_state <= CONVERT;
                        end
                    end
                end
                CONVERT: begin
                    r_result       <= r_sign ? (~w_mag + 1'b1) : w_mag;
                    r_result_valid <= 1'b1;
                    r_state        <= HOLD;
                end
                HOLD: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_bit_cnt      <= '0;
                    r_ones_cnt     <= '0;
                    r_seen_zero    <= 1'b0;
                    r_sign         <= 1'b0;
                    r_busy         <= 1'b0;
                    r_result_valid <= 1'b0;
                    r_result       <= '0;
                    r_code_error   <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign code_error   = r_code_error;

endmodule
`default_nettype wire

// File: tb/tb_serial_thermo_to_scomp.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_thermo_to_scomp
// Brief    : Self-checking bench for serial_thermo_to_scomp (N=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_thermo_to_scomp;

    localparam int c_N     = 4;
    localparam int c_TOTAL = 15;

    logic         clk;
    logic         reset;
    logic         start;
    logic         sign_in;
    logic         bit_valid;
    logic         bit_in;
    logic         result_ready;
    logic         busy;
    logic         result_valid;
    logic [c_N:0] result;
    logic         code_error;

    int checks;
    int errors;

    serial_thermo_to_scomp #(.N(c_N)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .sign_in      (sign_in),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .result_ready (result_ready),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .code_error   (code_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: signed value of the ones count.
    function automatic logic [c_N:0] model_result(input logic sign, input logic [14:0] bits);
        int ones;
        int v;
        logic [c_N:0] r;
        ones = $countones(bits);
        v    = sign ? -ones : ones;
        r    = v[c_N:0];
        return r;
    endfunction

    // Reference model: valid iff stream equals the ideal thermometer of its ones count.
    function automatic logic model_error(input logic [14:0] bits);
        int ones;
        logic [14:0] ideal;
        ones  = $countones(bits);
        ideal = 15'((32'd1 << ones) - 1);
        return (bits != ideal);
    endfunction

    // Starts a conversion and feeds all bits; returns right after the final bit's edge.
    task automatic send_stream(input logic sign, input logic [14:0] bits, input bit gaps);
        start   = 1'b1;
        sign_in = sign;
        tick();
        start   = 1'b0;
        sign_in = $urandom_range(0, 1);
        for (int i = 0; i < c_TOTAL; i++) begin
            while (gaps && ($urandom_range(0, 2) == 0)) begin
                bit_valid = 1'b0;
                bit_in    = $urandom_range(0, 1);
                tick();
            end
            bit_valid = 1'b1;
            bit_in    = bits[i];
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if ({busy, result_valid, result, code_error} !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b valid=%b result=%b err=%b, expected all 0",
                     busy, result_valid, result, code_error);
        end
        reset = 1'b0;
        tick();
        // bit_valid and result_ready in IDLE must not wake the block
        bit_valid = 1'b1; bit_in = 1'b1; result_ready = 1'b1;
        tick(); tick();
        bit_valid = 1'b0; result_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: got busy=%b valid=%b, expected 0 0", busy, result_valid);
        end
    endtask

    task automatic test_directed();
        logic        signs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [14:0] pats  [4] = '{15'h001F, 15'h7FFF, 15'h0000, 15'h000B};
        logic [4:0]  exp_r [4] = '{5'b00101, 5'b10001, 5'b00000, 5'b00011};
        logic        exp_e [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            send_stream(signs[k], pats[k], 1'b0);
            checks++;
            if (result_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_early: got valid=%b busy=%b, expected 0 1", k, result_valid, busy);
            end
            tick();
            checks++;
            if (result_valid !== 1'b1 || result !== exp_r[k] || code_error !== exp_e[k]) begin
                errors++;
                $display("FAIL dir%0d_result: got valid=%b result=%b err=%b, expected 1 %b %b",
                         k, result_valid, result, code_error, exp_r[k], exp_e[k]);
            end
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
            checks++;
            if (result_valid !== 1'b0 || busy !== 1'b0 || result !== exp_r[k]) begin
                errors++;
                $display("FAIL dir%0d_release: got valid=%b busy=%b result=%b, expected 0 0 %b",
                         k, result_valid, busy, result, exp_r[k]);
            end
        end
    endtask

    task automatic test_hold_stall();
        logic [14:0] bits;
        logic [4:0]  exp_r;
        logic        exp_e;
        bits  = 15'((32'd1 << $urandom_range(1, 15)) - 1);
        exp_r = model_result(1'b1, bits);
        exp_e = model_error(bits);
        send_stream(1'b1, bits, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            start   = (c == 1);
            sign_in = 1'b0;
            checks++;
            if (result_valid !== 1'b1 || result !== exp_r || code_error !== exp_e || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_stable%0d: got valid=%b result=%b err=%b busy=%b, expected 1 %b %b 1",
                         c, result_valid, result, code_error, busy, exp_r, exp_e);
            end
            tick();
        end
        start = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== exp_r) begin
            errors++;
            $display("FAIL hold_exit: got busy=%b valid=%b result=%b, expected 0 0 %b",
                     busy, result_valid, result, exp_r);
        end
    endtask

    task automatic test_random();
        logic [14:0] bits;
        logic        sign;
        for (int t = 0; t < 40; t++) begin
            sign = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1)
                bits = 15'((32'd1 << $urandom_range(0, 15)) - 1);
            else
                bits = 15'($urandom);
            send_stream(sign, bits, 1'b1);
            tick();
            checks++;
            if (result_valid !== 1'b1 || result !== model_result(sign, bits)
                || code_error !== model_error(bits)) begin
                errors++;
                $display("FAIL rand%0d: bits=%h sign=%b got valid=%b result=%b err=%b, expected 1 %b %b",
                         t, bits, sign, result_valid, result, code_error,
                         model_result(sign, bits), model_error(bits));
            end
            repeat ($urandom_range(0, 2)) tick();
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] bits;
        logic        sign;
        for (int t = 0; t < 4; t++) begin
            sign = t[0];
            bits = 15'((32'd1 << $urandom_range(0, 15)) - 1);
            send_stream(sign, bits, 1'b0);
            tick();
            checks++;
            if (result !== model_result(sign, bits) || result_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b%0d: got valid=%b result=%b, expected 1 %b",
                         t, result_valid, result, model_result(sign, bits));
            end
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
        end
    endtask

    task automatic test_mid_reset();
        start = 1'b1; sign_in = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, result_valid, result, code_error} !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b valid=%b result=%b err=%b, expected all 0",
                     busy, result_valid, result, code_error);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            tick();
            checks++;
            if (result_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset%0d: got valid=%b busy=%b, expected 0 0", i, result_valid, busy);
            end
        end
        bit_valid = 1'b0;
        send_stream(1'b0, 15'h0007, 1'b0);
        tick();
        checks++;
        if (result_valid !== 1'b1 || result !== 5'b00011 || code_error !== 1'b0) begin
            errors++;
            $display("FAIL fresh_after_reset: got valid=%b result=%b err=%b, expected 1 00011 0",
                     result_valid, result, code_error);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; start = 1'b0; sign_in = 1'b0;
        bit_valid = 1'b0; bit_in = 1'b0; result_ready = 1'b0;
        test_reset();
        test_directed();
        test_hold_stall();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
